// File: rtl/topeira_pkg.sv
// topeira_pkg: shared key-index type, key count, debounce FSM states and default timing.
// Used by key_conditioner and key_debounce (optional KEY_REPEAT_EN lives in those files).
package topeira_pkg;

    localparam int NUM_KEYS            = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_CYCLES   = 25000000;

    typedef logic [1:0] key_idx_t;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_WAIT_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_WAIT_UP = 2'd3
    } deb_state_t;

    function automatic key_idx_t lowest_key(input logic [NUM_KEYS-1:0] q);
        lowest_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (q[i]) lowest_key = key_idx_t'(i);
        end
    endfunction

    function automatic logic multi_key(input logic [NUM_KEYS-1:0] q);
        return (q & (q - NUM_KEYS'(1))) != '0;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus UP/WAIT_DN/DOWN/WAIT_UP debounce FSM for one key.
// Auto-repeat while held in DOWN is built only when KEY_REPEAT_EN is defined.
module key_debounce
    import topeira_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that enters a WAIT state and the one that leaves it both count
    // toward the stable time, so the counter only has to cover the cycles between.
    localparam int DWELL = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [CNT_W-1:0] CNT_DWELL = CNT_W'(DWELL);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_p0;
    logic             sync_p1;
    logic             sync;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             dwell_done;

    // Synchronizer: reset to the released (high) level of the active-low key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign sync       = ~sync_p1;
    assign dwell_done = (cnt >= CNT_DWELL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_UP;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_UP:      if (sync) state_next = ST_WAIT_DN;
            ST_WAIT_DN: begin
                if (!sync)           state_next = ST_UP;
                else if (dwell_done) state_next = ST_DOWN;
            end
            ST_DOWN:    if (!sync) state_next = ST_WAIT_UP;
            ST_WAIT_UP: begin
                if (sync)            state_next = ST_DOWN;
                else if (dwell_done) state_next = ST_UP;
            end
            default:    state_next = ST_UP;
        endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_fire;

    assign rpt_fire = (state == ST_DOWN) && sync && (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));

    // Repeat timer runs only while the key stays in DOWN; leaving DOWN clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt <= '0;
        end else if ((state != ST_DOWN) || !sync || rpt_fire) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`endif

    always_comb begin
        level = (state == ST_DOWN) || (state == ST_WAIT_UP);
        press = (state == ST_WAIT_DN) && sync && dwell_done;
`ifdef KEY_REPEAT_EN
        press = press || rpt_fire;
`endif
    end

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: four debounced pushbuttons feeding a single-entry press-event register.
// Define KEY_REPEAT_EN to add auto-repeat press events while a key stays held.
module key_conditioner
    import topeira_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [3:0] iKEY,
    output logic [3:0] oKEY_LEVEL,
    output logic       oEVT_VALID,
    input  logic       iEVT_READY,
    output logic [1:0] oEVT_CODE,
    output logic       oEVT_MULTI,
    output logic       oOVERRUN
);

    logic [NUM_KEYS-1:0] press;
    logic                xfer;
    logic                load;
    logic                drop;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_debounce (
            .clk    (iCLK),
            .rst_n  (iRST_N),
            .key_raw(iKEY[i]),
            .level  (oKEY_LEVEL[i]),
            .press  (press[i])
        );
    end

    // A new press is taken when the register is empty or draining this cycle;
    // otherwise it is lost and recorded in the sticky overrun flag.
    assign xfer = oEVT_VALID && iEVT_READY;
    assign load = (|press) && (!oEVT_VALID || xfer);
    assign drop = (|press) && oEVT_VALID && !xfer;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oEVT_VALID <= 1'b0;
            oEVT_CODE  <= '0;
            oEVT_MULTI <= 1'b0;
            oOVERRUN   <= 1'b0;
        end else begin
            if (load) begin
                oEVT_VALID <= 1'b1;
                oEVT_CODE  <= lowest_key(press);
                oEVT_MULTI <= multi_key(press);
            end else if (xfer) begin
                oEVT_VALID <= 1'b0;
            end
            if (drop) begin
                oOVERRUN <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus randomized key/ready/reset traffic,
// checked every cycle against a run-length reference model of the key conditioner.
module tb_key_conditioner;

    localparam int DEB = 4;
    localparam int RPT = 10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key   = 4'hF;
    logic       ready = 1'b0;
    logic [3:0] level;
    logic       valid;
    logic [1:0] code;
    logic       multi;
    logic       ovr;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iKEY      (key),
        .oKEY_LEVEL(level),
        .oEVT_VALID(valid),
        .iEVT_READY(ready),
        .oEVT_CODE (code),
        .oEVT_MULTI(multi),
        .oOVERRUN  (ovr)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         dut_evts = 0;
    int         ev0;
    logic [1:0] last_code = 2'd0;

    // Reference model: raw key delay line, run length of the synced value, debounced level
    logic [3:0] m_q1, m_q2, m_prev, m_level;
    int         m_run [4];
`ifdef KEY_REPEAT_EN
    int         m_rep [4];
`endif
    logic       m_valid, m_multi, m_ovr;
    logic [1:0] m_code;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1    = 4'hF;
        m_q2    = 4'hF;
        m_prev  = 4'h0;
        m_level = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = 0;
`ifdef KEY_REPEAT_EN
            m_rep[i] = 0;
`endif
        end
        m_valid = 1'b0;
        m_code  = 2'd0;
        m_multi = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // One clock edge: a level flips once the synced value has differed from it for DEB
    // consecutive samples; each new press (and each full repeat period held) is a qualifier.
    task automatic model_step();
        logic [3:0] s;
        logic [3:0] qual;
        logic       xfer;
        s    = ~m_q2;
        qual = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (s[i] == m_prev[i]) m_run[i]++;
            else                   m_run[i] = 1;
            if (m_run[i] > 1000) m_run[i] = 1000;
`ifdef KEY_REPEAT_EN
            if (m_level[i] && s[i] && m_prev[i]) begin
                m_rep[i]++;
                if (m_rep[i] == RPT) begin
                    qual[i]  = 1'b1;
                    m_rep[i] = 0;
                end
            end else begin
                m_rep[i] = 0;
            end
`endif
            if ((s[i] != m_level[i]) && (m_run[i] >= DEB)) begin
                m_level[i] = s[i];
                if (s[i]) qual[i] = 1'b1;
            end
            m_prev[i] = s[i];
        end
        xfer = m_valid && ready;
        if (qual != 4'h0) begin
            if (!m_valid || xfer) begin
                m_valid = 1'b1;
                m_multi = ($countones(qual) > 1);
                for (int i = 3; i >= 0; i--) if (qual[i]) m_code = 2'(i);
            end else begin
                m_ovr = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        m_q2 = m_q1;
        m_q1 = key;
    endtask

    task automatic tick();
        if (valid && ready) begin
            dut_evts++;
            last_code = code;
        end
        @(posedge clk);
        model_step();
        #1;
        check("level", 32'(level), 32'(m_level));
        check("valid", 32'(valid), 32'(m_valid));
        check("code",  32'(code),  32'(m_code));
        check("multi", 32'(multi), 32'(m_multi));
        check("ovr",   32'(ovr),   32'(m_ovr));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Called just after a clock edge; outputs must clear before the next edge arrives
    task automatic reset_pulse(input int cycles);
        rst_n = 1'b0;
        #2;
        check("rst_async_level", 32'(level), 32'h0);
        check("rst_async_valid", 32'(valid), 32'h0);
        check("rst_async_code",  32'(code),  32'h0);
        check("rst_async_multi", 32'(multi), 32'h0);
        check("rst_async_ovr",   32'(ovr),   32'h0);
        model_reset();
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("rst_hold_valid", 32'(valid), 32'h0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_level", 32'(level), 32'h0);
        check("init_valid", 32'(valid), 32'h0);
        check("init_code",  32'(code),  32'h0);
        check("init_multi", 32'(multi), 32'h0);
        check("init_ovr",   32'(ovr),   32'h0);
        rst_n = 1'b1;
        ticks(3);

        // Glitchy KEY2 then a stable press
        ready = 1'b1;
        key[2] = 1'b0; ticks(3); key[2] = 1'b1; ticks(2);
        key[2] = 1'b0; ticks(3); key[2] = 1'b1; ticks(2);
        ev0 = dut_evts;
        key[2] = 1'b0;
        ticks(5);
        check("s1_level_early", 32'(level), 32'h0);
        tick();
        check("s1_level", 32'(level), 32'b0100);
        check("s1_valid", 32'(valid), 32'h1);
        check("s1_code",  32'(code),  32'h2);
        ticks(3);
        key = 4'hF;
        ticks(10);
        check("s1_events", 32'(dut_evts - ev0), 32'd1);
        check("s1_evt_code", 32'(last_code), 32'h2);

        // KEY1 and KEY3 together
        ready = 1'b0;
        ev0 = dut_evts;
        key = 4'b0101;
        ticks(6);
        check("s2_level", 32'(level), 32'b1010);
        check("s2_valid", 32'(valid), 32'h1);
        check("s2_code",  32'(code),  32'h1);
        check("s2_multi", 32'(multi), 32'h1);
        ready = 1'b1;
        ticks(4);
        check("s2_events", 32'(dut_evts - ev0), 32'd1);
        check("s2_drained", 32'(valid), 32'h0);
        key = 4'hF;
        ticks(10);

        // Overrun: KEY0 held pending, KEY2 arrives
        ready = 1'b0;
        key = 4'b1110;
        ticks(8);
        check("s3_code0", 32'(code), 32'h0);
        check("s3_ovr0",  32'(ovr),  32'h0);
        key = 4'b1010;
        ticks(8);
        check("s3_code",  32'(code),  32'h0);
        check("s3_ovr",   32'(ovr),   32'h1);
        check("s3_valid", 32'(valid), 32'h1);
        ready = 1'b1;
        tick();
        check("s3_drained", 32'(valid), 32'h0);
        key = 4'hF;
        ticks(10);

        // Reset while KEY3 is held re-qualifies it after release
        ready = 1'b1;
        key = 4'b0111;
        ticks(10);
        check("s5_level_before", 32'(level), 32'b1000);
        ev0 = dut_evts;
        reset_pulse(2);
        ticks(5);
        check("s5_valid_early", 32'(valid), 32'h0);
        check("s5_level_early", 32'(level), 32'h0);
        tick();
        check("s5_valid", 32'(valid), 32'h1);
        check("s5_code",  32'(code),  32'h3);
        check("s5_level", 32'(level), 32'b1000);
        ticks(3);
        check("s5_events", 32'(dut_evts - ev0), 32'd1);
        key = 4'hF;
        ticks(10);

        // Qualifier lands in the transfer cycle
        ready = 1'b0;
        key = 4'b1110;
        ticks(6);
        check("s4_valid0", 32'(valid), 32'h1);
        check("s4_code0",  32'(code),  32'h0);
        key = 4'b1100;
        ticks(5);
        ready = 1'b1;
        tick();
        check("s4_valid", 32'(valid), 32'h1);
        check("s4_code",  32'(code),  32'h1);
        check("s4_ovr",   32'(ovr),   32'h0);
        tick();
        check("s4_drained", 32'(valid), 32'h0);
        key = 4'hF;
        ticks(10);

        // KEY0 held 30 cycles past qualification
        ready = 1'b1;
        ev0 = dut_evts;
        key = 4'b1110;
        ticks(6);
        check("s6_level", 32'(level), 32'b0001);
        ticks(30);
        key = 4'hF;
        ticks(12);
`ifdef KEY_REPEAT_EN
        check("s6_events", 32'(dut_evts - ev0), 32'd4);
`else
        check("s6_events", 32'(dut_evts - ev0), 32'd1);
`endif

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 9) == 0) key[b] = ~key[b];
            end
            ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 699) == 0) reset_pulse(1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, which is the stable-input time (20 ms at 50 MHz) required before a key level is accepted.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 25000000, which is the hold time between auto-repeat events (used only with KEY_REPEAT_EN).
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock, CLOCK_50 domain.
REQ-004 SHALL have port iRST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port iKEY, input, 4 bits: raw pushbuttons, active-low, asynchronous to iCLK.
REQ-006 SHALL have port oKEY_LEVEL, output, 4 bits: debounced key state, active-high (1 = pressed).
REQ-007 SHALL have port oEVT_VALID, output, 1 bit: a press event is pending.
REQ-008 SHALL have port iEVT_READY, input, 1 bit: the consumer (game FSM) accepts the event.
REQ-009 SHALL have port oEVT_CODE, output, 2 bits: index 0-3 of the pressed key.
REQ-010 SHALL have port oEVT_MULTI, output, 1 bit: more than one key qualified in the same cycle.
REQ-011 SHALL have port oOVERRUN, output, 1 bit: sticky flag indicating a press event was dropped.

Function
REQ-012 SHALL pass each iKEY bit through a 2-flop synchronizer, then invert it to active-high.
REQ-013 SHALL run a per-key debounce FSM with states UP, WAIT_DN, DOWN, WAIT_UP.
- UP->WAIT_DN on sync=1.
- WAIT_DN->UP on sync=0.
- WAIT_DN->DOWN after DEBOUNCE_CYCLES consecutive sync=1.
- DOWN->WAIT_UP on sync=0.
- WAIT_UP->DOWN on sync=1.
- WAIT_UP->UP after DEBOUNCE_CYCLES consecutive sync=0.
REQ-014 SHALL clear the per-key counter on every state entry; each counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits and saturate.
REQ-015 SHALL set oKEY_LEVEL[i]=1 in states DOWN and WAIT_UP; latency from an iKEY edge to oKEY_LEVEL is 2+DEBOUNCE_CYCLES cycles.
REQ-016 SHALL generate a press qualifier for key i for one cycle on the WAIT_DN->DOWN transition; releases SHALL generate no event.
REQ-017 SHALL hold events in a single-entry register; oEVT_CODE and oEVT_MULTI SHALL stay stable while oEVT_VALID=1 and iEVT_READY=0.
REQ-018 SHALL complete a transfer when oEVT_VALID=1 and iEVT_READY=1; oEVT_VALID SHALL drop the next cycle unless a new qualifier arrives.
REQ-019 SHALL, on simultaneous qualifiers, load oEVT_CODE = lowest index and set oEVT_MULTI=1.
REQ-020 SHALL, on a qualifier while the register is full and no transfer occurs that cycle, drop the new event, leave the register unchanged, and set oOVERRUN=1.
REQ-021 SHALL, on a qualifier in the same cycle as a transfer, load the new event with oEVT_VALID remaining 1 and no overrun.
REQ-022 SHALL permit iEVT_READY=1 while oEVT_VALID=0; this has no effect.

Reset
REQ-023 SHALL, on iRST_N=0, immediately set synchronizer flops to "released", all FSMs to UP, counters to 0, and oKEY_LEVEL, oEVT_VALID, oEVT_CODE, oEVT_MULTI and oOVERRUN to 0.
REQ-024 SHALL clear oOVERRUN only on reset.
REQ-025 SHALL, after a reset asserted mid-debounce or with a key held, re-qualify a held key from UP and emit one event 2+DEBOUNCE_CYCLES cycles after reset release.

Configuration
REQ-026 SHALL, with macro KEY_REPEAT_EN defined, give each key a repeat counter in DOWN that emits an additional press qualifier every REPEAT_CYCLES cycles while held; the counter SHALL be cleared on leaving DOWN.
REQ-027 SHALL, without KEY_REPEAT_EN, emit exactly one event per debounced press, with no repeat logic synthesized.

Structure
REQ-028 SHALL place in shared package topeira_pkg: the key-index type (2 bits), the NUM_KEYS=4 constant, the debounce FSM state enum, and the default cycle constants.
REQ-029 SHALL implement the synchronizer plus debounce FSM as sub-module key_debounce, instantiated 4 times; event arbitration and the register SHALL live in key_conditioner.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
REQ-030 SHALL verify: iKEY[2] low with 3-cycle glitches then stable -> oKEY_LEVEL=4'b0100 exactly 6 cycles after the stable edge, and one event with CODE=2.
REQ-031 SHALL verify: KEY1 and KEY3 pressed in the same cycle -> one event with CODE=1 and MULTI=1, and oKEY_LEVEL=4'b1010.
REQ-032 SHALL verify: iEVT_READY=0, KEY0 pressed then KEY2 pressed -> CODE stays 0, oOVERRUN=1; after READY, VALID=0.
REQ-033 SHALL verify: a qualifier arriving in the transfer cycle -> VALID stays 1, CODE updates, OVERRUN=0.
REQ-034 SHALL verify: iRST_N pulsed low while KEY3 held -> all outputs 0 asynchronously, then one CODE=3 event 6 cycles after release.
REQ-035 SHALL verify, with KEY_REPEAT_EN, KEY0 held 30 cycles past qualification -> 4 events total; without the macro -> 1 event.
